// File: rtl/ysyx_23060203_axi_pkg.sv
// ysyx_23060203_axi_pkg: shared AXI burst/response encodings and responder state type
package ysyx_23060203_axi_pkg;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  typedef enum logic [1:0] {IDLE, WAIT, BURST} state_t;
endpackage

// File: rtl/ysyx_23060203_axi_addr_gen.sv
// ysyx_23060203_axi_addr_gen: next beat address and burst legality for AXI read bursts
module ysyx_23060203_axi_addr_gen
  import ysyx_23060203_axi_pkg::*;
(
  input  logic [31:0] i_addr,
  input  logic [2:0]  i_size,
  input  logic [7:0]  i_len,
  input  logic [1:0]  i_burst,
  output logic [31:0] o_next_addr,
  output logic        o_illegal
);
  logic [31:0] w_incr;
  logic [31:0] w_mask;
  logic        w_wrap_ok;
  // step by beat size; WRAP keeps the upper bits of the aligned (len+1)<<size window
  always_comb begin
    w_incr      = i_addr + (32'd1 << i_size);
    w_mask      = (({24'd0, i_len} + 32'd1) << i_size) - 32'd1;
    w_wrap_ok   = (i_len == 8'd1) || (i_len == 8'd3) || (i_len == 8'd7) || (i_len == 8'd15);
    o_next_addr = (i_burst == BURST_INCR) ? w_incr :
                  (i_burst == BURST_WRAP) ? ((i_addr & ~w_mask) | (w_incr & w_mask)) : i_addr;
    o_illegal   = (i_size > 3'd2) || ((i_burst == BURST_WRAP) && !w_wrap_ok);
  end
endmodule

// File: rtl/ysyx_23060203_axi_rd_slave.sv
// ysyx_23060203_axi_rd_slave: AXI4 read responder streaming bursts from a word-wide synchronous memory
module ysyx_23060203_axi_rd_slave
  import ysyx_23060203_axi_pkg::*;
#(
  parameter logic [31:0] BASE      = 32'h80000000,
  parameter int          SIZE_LOG2 = 27,
  parameter int          LATENCY   = 0,
  parameter int          ID_W      = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 mem_r_arvalid,
  output logic                 mem_r_arready,
  input  logic [31:0]          mem_r_araddr,
  input  logic [ID_W-1:0]      mem_r_arid,
  input  logic [7:0]           mem_r_arlen,
  input  logic [2:0]           mem_r_arsize,
  input  logic [1:0]           mem_r_arburst,
  output logic                 mem_r_rvalid,
  input  logic                 mem_r_rready,
  output logic [31:0]          mem_r_rdata,
  output logic [1:0]           mem_r_rresp,
  output logic                 mem_r_rlast,
  output logic [ID_W-1:0]      mem_r_rid,
  output logic                 rd_en,
  output logic [SIZE_LOG2-3:0] rd_addr,
  input  logic [31:0]          rd_data
);
  state_t          r_state, w_next;
  logic [31:0]     r_addr, r_hold, w_next_addr, w_off;
  logic [ID_W-1:0] r_id;
  logic [7:0]      r_len, r_cnt;
  logic [2:0]      r_size;
  logic [1:0]      r_burst, r_rresp;
  logic [8:0]      r_issued;
  logic            r_rvalid, r_rlast, r_fresh;
  logic            w_illegal, w_err, w_issue, w_ar_hs, w_done;

  ysyx_23060203_axi_addr_gen u_addr_gen (
    .i_addr      (r_addr),
    .i_size      (r_size),
    .i_len       (r_len),
    .i_burst     (r_burst),
    .o_next_addr (w_next_addr),
    .o_illegal   (w_illegal)
  );

  // beat issue decision, error classification and FSM next state
  always_comb begin
    w_off         = r_addr - BASE;
    w_err         = w_illegal || ((w_off >> SIZE_LOG2) != 32'd0);
    mem_r_arready = (r_state == IDLE) && !reset;
    w_ar_hs       = mem_r_arvalid && mem_r_arready;
    w_issue       = (r_state == BURST) && (r_issued <= {1'b0, r_len}) && (!r_rvalid || mem_r_rready);
    w_done        = r_rvalid && mem_r_rready && r_rlast;
    w_next        = (r_state == IDLE)  ? (w_ar_hs ? ((LATENCY > 0) ? WAIT : BURST) : IDLE) :
                    (r_state == WAIT)  ? ((r_cnt == 8'd0) ? BURST : WAIT) :
                    (w_done ? IDLE : BURST);
    rd_en         = w_issue && !w_err;
    rd_addr       = w_off[SIZE_LOG2-1:2];
    mem_r_rvalid  = r_rvalid;
    mem_r_rdata   = r_fresh ? rd_data : r_hold;
    mem_r_rresp   = r_rresp;
    mem_r_rlast   = r_rlast;
    mem_r_rid     = r_id;
  end

  // FSM state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // request latch, latency countdown and R-channel beat registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_addr   <= '0;
      r_id     <= '0;
      r_len    <= '0;
      r_size   <= '0;
      r_burst  <= '0;
      r_issued <= '0;
      r_cnt    <= '0;
      r_rvalid <= 1'b0;
      r_rlast  <= 1'b0;
      r_rresp  <= RESP_OKAY;
      r_fresh  <= 1'b0;
      r_hold   <= '0;
    end else begin
      if (w_ar_hs) begin
        r_addr   <= mem_r_araddr;
        r_id     <= mem_r_arid;
        r_len    <= mem_r_arlen;
        r_size   <= mem_r_arsize;
        r_burst  <= mem_r_arburst;
        r_issued <= '0;
        r_cnt    <= 8'(LATENCY - 1);
      end else if (r_state == WAIT) r_cnt <= r_cnt - 8'd1;
      if (w_issue) begin
        r_addr   <= w_next_addr;
        r_issued <= r_issued + 9'd1;
        r_rvalid <= 1'b1;
        r_rlast  <= (r_issued[7:0] == r_len);
        r_rresp  <= w_err ? RESP_SLVERR : RESP_OKAY;
        r_fresh  <= !w_err;
      end else begin
        r_fresh  <= 1'b0;
        if (mem_r_rready) r_rvalid <= 1'b0;
      end
      r_hold <= (w_issue && w_err) ? 32'd0 : r_fresh ? rd_data : r_hold;
    end
  end

`ifndef SYNTHESIS
  logic [31:0] r_perf_beats, r_perf_stalls;
  // simulation-only counters: accepted beats and R stall cycles
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_perf_beats  <= '0;
      r_perf_stalls <= '0;
    end else begin
      r_perf_beats  <= r_perf_beats + 32'(r_rvalid && mem_r_rready);
      r_perf_stalls <= r_perf_stalls + 32'(r_rvalid && !mem_r_rready);
    end
  end
`endif
endmodule
